// File: rtl/alu_pkg.sv
// Opcode table and FSM encodings shared by the ALU arbiter and its core.
package alu_pkg;

   localparam int ALU_W   = 4;
   localparam int ALU_OPW = 4;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_AND   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_XOR   = 4'h4;
   localparam logic [3:0] OP_NAND  = 4'h5;
   localparam logic [3:0] OP_NOR   = 4'h6;
   localparam logic [3:0] OP_XNOR  = 4'h7;
   localparam logic [3:0] OP_NOTA  = 4'h8;
   localparam logic [3:0] OP_PASSA = 4'h9;
   localparam logic [3:0] OP_PASSB = 4'hA;
   localparam logic [3:0] OP_INC   = 4'hB;
   localparam logic [3:0] OP_DEC   = 4'hC;
   localparam logic [3:0] OP_SHL   = 4'hD;
   localparam logic [3:0] OP_SHR   = 4'hE;
   localparam logic [3:0] OP_ANDN  = 4'hF;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit, 16-function ALU; carry is borrow for SUB/DEC and the
// shifted-out bit for shifts, 0 for pure logic ops.
module alu_core
   import alu_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] op,
   output logic [3:0] result,
   output logic       carry
);

   logic [4:0] wide;

   always_comb begin
      wide = '0;
      case (op)
         OP_ADD:   wide = {1'b0, a} + {1'b0, b};
         OP_SUB:   wide = {1'b0, a} - {1'b0, b};
         OP_AND:   wide = {1'b0, a & b};
         OP_OR:    wide = {1'b0, a | b};
         OP_XOR:   wide = {1'b0, a ^ b};
         OP_NAND:  wide = {1'b0, ~(a & b)};
         OP_NOR:   wide = {1'b0, ~(a | b)};
         OP_XNOR:  wide = {1'b0, ~(a ^ b)};
         OP_NOTA:  wide = {1'b0, ~a};
         OP_PASSA: wide = {1'b0, a};
         OP_PASSB: wide = {1'b0, b};
         OP_INC:   wide = {1'b0, a} + 5'd1;
         OP_DEC:   wide = {1'b0, a} - 5'd1;
         OP_SHL:   wide = {a, 1'b0};
         OP_SHR:   wide = {a[0], 1'b0, a[3:1]};
         OP_ANDN:  wide = {1'b0, a & ~b};
         default:  wide = '0;
      endcase
   end

   assign result = wide[3:0];
   assign carry  = wide[4];

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared alu_core with a single
// registered, backpressured response channel tagged by requester ID.
module alu_req_arbiter #(
   parameter int W   = 4,
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [OPW-1:0] req0_op,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic [OPW-1:0] req1_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [W-1:0]   rsp_result,
   output logic           rsp_carry,
   output logic           rsp_zero
);
   import alu_pkg::*;

   logic [1:0]     state;
   logic           last_grant;
   logic           grant;
   logic [OPW-1:0] cap_op;
   logic [W-1:0]   cap_a;
   logic [W-1:0]   cap_b;
   logic           cap_id;
   logic [W-1:0]   core_result;
   logic           core_carry;

   // Contention goes to whoever did not win last; a lone request always wins.
   always_comb begin
      grant = 1'b0;
      if (req_valid == 2'b11) grant = ~last_grant;
      else if (req_valid[1])  grant = 1'b1;
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && state == S_IDLE && req_valid != 2'b00)
         req_ready = grant ? 2'b10 : 2'b01;
   end

   assign rsp_valid = (state == S_RESP);

   alu_core u_core (
      .a      (cap_a),
      .b      (cap_b),
      .op     (cap_op),
      .result (core_result),
      .carry  (core_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         cap_op     <= '0;
         cap_a      <= '0;
         cap_b      <= '0;
         cap_id     <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if ((req_valid & req_ready) != 2'b00) begin
                  cap_op     <= grant ? req1_op : req0_op;
                  cap_a      <= grant ? req1_a  : req0_a;
                  cap_b      <= grant ? req1_b  : req0_b;
                  cap_id     <= grant;
                  last_grant <= grant;
                  state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               rsp_result <= core_result;
               rsp_carry  <= core_carry;
               rsp_zero   <= (core_result == '0);
               rsp_id     <= cap_id;
               state      <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed plus randomized checks of alu_req_arbiter against an arithmetic
// model of the opcode table and the round-robin rule.
module tb_alu_req_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [3:0] req0_op, req0_a, req0_b;
   logic [3:0] req1_op, req1_a, req1_b;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [3:0] rsp_result;
   logic       rsp_carry;
   logic       rsp_zero;

   int vectors = 0;
   int miscompares = 0;
   int last_g = 1;

   alu_req_arbiter #(.W(4), .OPW(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_carry  (rsp_carry),
      .rsp_zero   (rsp_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference ALU from plain integer arithmetic on values 0..15.
   task automatic model(input int op, input int a, input int b, output int res, output int c);
      c = 0;
      case (op)
         0:  begin res = (a + b) % 16;      c = (a + b >= 16); end
         1:  begin res = (a - b + 16) % 16; c = (a < b);       end
         2:  res = a & b;
         3:  res = a | b;
         4:  res = a ^ b;
         5:  res = 15 - (a & b);
         6:  res = 15 - (a | b);
         7:  res = 15 - (a ^ b);
         8:  res = 15 - a;
         9:  res = a;
         10: res = b;
         11: begin res = (a + 1) % 16;  c = (a == 15); end
         12: begin res = (a + 15) % 16; c = (a == 0);  end
         13: begin res = (a * 2) % 16;  c = (a >= 8);  end
         14: begin res = a / 2;         c = a % 2;     end
         default: res = a & (15 - b);
      endcase
   endtask

   // Called just after a rising edge with the DUT idle.
   task automatic txn(input logic [1:0] v,
                      input logic [3:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                      input logic [3:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                      input int bp);
      int g, res, c, eop, ea, eb;
      req0_op = op0; req0_a = a0; req0_b = b0;
      req1_op = op1; req1_a = a1; req1_b = b1;
      req_valid = v;
      rsp_ready = (bp == 0);
      if (v == 2'b11) g = 1 - last_g;
      else            g = v[1] ? 1 : 0;
      last_g = g;
      eop = (g == 1) ? int'(op1) : int'(op0);
      ea  = (g == 1) ? int'(a1)  : int'(a0);
      eb  = (g == 1) ? int'(b1)  : int'(b0);
      model(eop, ea, eb, res, c);
      #1;
      chk("grant_ready", {6'd0, req_ready}, (g == 1) ? 8'd2 : 8'd1);
      @(posedge clk); #1;
      req_valid = v & ~(2'b01 << g);
      req0_a = ~req0_a; req1_b = ~req1_b;
      chk("exec_valid", {7'd0, rsp_valid}, 8'd0);
      chk("exec_ready", {6'd0, req_ready}, 8'd0);
      @(posedge clk); #1;
      chk("rsp_valid",  {7'd0, rsp_valid}, 8'd1);
      chk("rsp_id",     {7'd0, rsp_id}, 8'(g));
      chk("rsp_result", {4'd0, rsp_result}, 8'(res));
      chk("rsp_carry",  {7'd0, rsp_carry}, 8'(c));
      chk("rsp_zero",   {7'd0, rsp_zero}, (res == 0) ? 8'd1 : 8'd0);
      for (int k = 0; k < bp; k++) begin
         @(posedge clk); #1;
         chk("bp_valid",  {7'd0, rsp_valid}, 8'd1);
         chk("bp_ready",  {6'd0, req_ready}, 8'd0);
         chk("bp_result", {3'd0, rsp_carry, rsp_result}, 8'((c * 16) + res));
         chk("bp_id",     {7'd0, rsp_id}, 8'(g));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("done_valid", {7'd0, rsp_valid}, 8'd0);
      chk("held_result", {4'd0, rsp_result}, 8'(res));
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 2'b00; rsp_ready = 1'b0;
      req0_op = '0; req0_a = '0; req0_b = '0;
      req1_op = '0; req1_a = '0; req1_b = '0;
      #12;
      chk("por_valid", {7'd0, rsp_valid}, 8'd0);
      chk("por_payload", {2'd0, rsp_id, rsp_carry, rsp_zero, 3'd0} | {4'd0, rsp_result}, 8'd0);
      rst_n = 1'b1;
      req_valid = 2'b11;
      #1;
      chk("first_ready", {6'd0, req_ready}, 8'd1);
      req_valid = 2'b00;
      @(posedge clk); #1;

      // Logic op, then arithmetic wrap and zero from requester 1.
      txn(2'b01, OP_XOR(), 4'hA, 4'h6, 4'h0, 4'h0, 4'h0, 0);
      txn(2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h9, 4'h8, 0);
      txn(2'b10, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h3, 0);

      // Contention: both valid for four operations.
      for (int i = 0; i < 4; i++)
         txn(2'b11, 4'h0, 4'(i), 4'h1, 4'h2, 4'hF, 4'(i), 0);

      // Five stalled cycles in RESP.
      txn(2'b11, 4'h1, 4'h2, 4'h5, 4'h3, 4'h8, 4'h1, 5);

      // Reset while a command is in EXEC.
      req_valid = 2'b01; req0_op = 4'h0; req0_a = 4'h7; req0_b = 4'h7; rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 2'b00;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {7'd0, rsp_valid}, 8'd0);
      chk("rst_ready", {6'd0, req_ready}, 8'd0);
      chk("rst_payload", {1'b0, rsp_id, rsp_carry, rsp_zero, rsp_result}, 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      last_g = 1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("no_ghost_rsp", {7'd0, rsp_valid}, 8'd0);
      end
      txn(2'b11, 4'h3, 4'h5, 4'hA, 4'h2, 4'hF, 4'hF, 0);

      // Randomized traffic.
      for (int i = 0; i < 60; i++) begin
         logic [1:0] v;
         v = 2'($urandom_range(1, 3));
         txn(v, 4'($urandom), 4'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   function automatic logic [3:0] OP_XOR();
      return 4'h4;
   endfunction

endmodule
